// File: rtl/chacha20_xor_stream.sv
`default_nettype none
// ============================================================================
// Module      : chacha20_xor_stream
// Description : ChaCha20 keystream consumer. Fetches 512-bit keystream blocks
//               from the generator and XORs their sixteen 32-bit words, in
//               order, into a valid/ready data stream. The block counter
//               advances per block and saturates at 0xFFFFFFFF.
// Build option: CHACHA_PREFETCH_EN - adds a shadow block buffer so the next
//               block is fetched while the current one streams.
// Revision    : 1.0 - initial release
// ============================================================================
module chacha20_xor_stream (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         init_i,
  input  logic [31:0]  init_counter_i,
  output logic         ks_start_o,
  output logic [31:0]  ks_counter_o,
  input  logic [511:0] ks_block_i,
  input  logic         ks_done_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [31:0]  out_data_o,
  output logic         busy_o,
  output logic         ctr_exhausted_o
);

  localparam logic [31:0] CTR_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    ctr_q, ctr_d;
  logic [511:0]   buf_q, buf_d;
  logic [3:0]     idx_q, idx_d;
  logic           ov_q, ov_d;
  logic [31:0]    od_q, od_d;
  logic           exh_q, exh_d;

  logic [31:0]    w_word;
  logic           w_in_ready;
  logic           w_acc;
  logic           w_last;
  logic           w_max;

`ifdef CHACHA_PREFETCH_EN
  logic [511:0]   sh_q, sh_d;       // shadow (next) block
  logic           shv_q, shv_d;     // shadow holds a valid block
  logic           pfo_q, pfo_d;     // prefetch request outstanding
  logic           pfs_q, pfs_d;     // prefetch start pulse
  logic           dfr_q, dfr_d;     // init deferred until prefetch returns
  logic [31:0]    dctr_q, dctr_d;   // counter carried by the deferred init
  logic [31:0]    kc_q, kc_d;       // counter of the request in flight
  logic           w_sh_rdy;
  logic [511:0]   w_sh_blk;

  // A block arriving in the same cycle as word 15 is promoted directly
  assign w_sh_rdy     = shv_q || (pfo_q && ks_done_i);
  assign w_sh_blk     = shv_q ? sh_q : ks_block_i;
  assign ks_start_o   = (state_q == S_REQ) || pfs_q;
  assign ks_counter_o = (state_q == S_REQ) ? ctr_q : kc_q;
`else
  assign ks_start_o   = (state_q == S_REQ);
  assign ks_counter_o = ctr_q;
`endif

  assign w_word          = buf_q[{idx_q, 5'd0} +: 32];
  // init in STREAM discards the block, so no word is taken that cycle
  assign w_in_ready      = (state_q == S_STREAM) && !init_i && (!ov_q || out_ready_i);
  assign w_acc           = w_in_ready && in_valid_i;
  assign w_last          = w_acc && (idx_q == 4'd15);
  assign w_max           = (ctr_q == CTR_MAX);
  assign in_ready_o      = w_in_ready;
  assign out_valid_o     = ov_q;
  assign out_data_o      = od_q;
  assign busy_o          = (state_q != S_IDLE);
  assign ctr_exhausted_o = exh_q;

  // Next-state, datapath and block-sequencing decisions
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    exh_d   = exh_q;
    od_d    = od_q;
    ov_d    = ov_q && !out_ready_i;
`ifdef CHACHA_PREFETCH_EN
    sh_d    = sh_q;
    shv_d   = shv_q;
    pfo_d   = pfo_q;
    pfs_d   = 1'b0;
    dfr_d   = dfr_q;
    dctr_d  = dctr_q;
    kc_d    = kc_q;
`endif
    if (w_acc) begin
      ov_d  = 1'b1;
      od_d  = in_data_i ^ w_word;
      idx_d = idx_q + 4'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (init_i) begin
          ctr_d   = init_counter_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
`ifdef CHACHA_PREFETCH_EN
        kc_d    = ctr_q;
`endif
      end
      S_WAIT: begin
        if (ks_done_i) begin
`ifdef CHACHA_PREFETCH_EN
          pfo_d = 1'b0;
          if (dfr_q) begin
            dfr_d   = 1'b0;
            ctr_d   = dctr_q;
            state_d = S_REQ;
          end else begin
            buf_d   = ks_block_i;
            idx_d   = 4'd0;
            state_d = S_STREAM;
            if (!w_max) begin
              pfs_d = 1'b1;
              pfo_d = 1'b1;
              kc_d  = ctr_q + 32'd1;
            end
          end
`else
          buf_d   = ks_block_i;
          idx_d   = 4'd0;
          state_d = S_STREAM;
`endif
        end
      end
      S_STREAM: begin
        if (init_i) begin
`ifdef CHACHA_PREFETCH_EN
          shv_d = 1'b0;
          if (pfo_q && !ks_done_i) begin
            dfr_d   = 1'b1;
            dctr_d  = init_counter_i;
            state_d = S_WAIT;
          end else begin
            pfo_d   = 1'b0;
            ctr_d   = init_counter_i;
            state_d = S_REQ;
          end
`else
          ctr_d   = init_counter_i;
          state_d = S_REQ;
`endif
        end else if (w_last) begin
          if (w_max) begin
            exh_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            ctr_d = ctr_q + 32'd1;
`ifdef CHACHA_PREFETCH_EN
            if (w_sh_rdy) begin
              buf_d = w_sh_blk;
              shv_d = 1'b0;
              pfo_d = 1'b0;
              if ((ctr_q + 32'd1) != CTR_MAX) begin
                pfs_d = 1'b1;
                pfo_d = 1'b1;
                kc_d  = ctr_q + 32'd2;
              end
            end else if (pfo_q) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_REQ;
            end
`else
            state_d = S_REQ;
`endif
          end
        end
`ifdef CHACHA_PREFETCH_EN
        else if (pfo_q && ks_done_i) begin
          sh_d  = ks_block_i;
          shv_d = 1'b1;
          pfo_d = 1'b0;
        end
`endif
      end
      S_HALT: begin
        if (init_i) begin
          ctr_d   = init_counter_i;
          exh_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Core state, active block and output register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ctr_q   <= 32'd0;
      buf_q   <= 512'd0;
      idx_q   <= 4'd0;
      ov_q    <= 1'b0;
      od_q    <= 32'd0;
      exh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      exh_q   <= exh_d;
    end
  end

`ifdef CHACHA_PREFETCH_EN
  // Shadow buffer and prefetch bookkeeping
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sh_q   <= 512'd0;
      shv_q  <= 1'b0;
      pfo_q  <= 1'b0;
      pfs_q  <= 1'b0;
      dfr_q  <= 1'b0;
      dctr_q <= 32'd0;
      kc_q   <= 32'd0;
    end else begin
      sh_q   <= sh_d;
      shv_q  <= shv_d;
      pfo_q  <= pfo_d;
      pfs_q  <= pfs_d;
      dfr_q  <= dfr_d;
      dctr_q <= dctr_d;
      kc_q   <= kc_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/chacha20_xor_stream.md
# chacha20_xor_stream

Keystream consumer for the ChaCha20 datapath. Requests 512-bit keystream blocks from the keystream generator, buffers them, and XORs each block's sixteen 32-bit words, in order, into a valid/ready stream of 32-bit data words. The block counter is advanced automatically per block. It sits between the host data path and the keystream generator: it drives the generator's `start`/`counter` and consumes its `keystream`/`done`.

## Interface
- No parameters.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `init`  in  1  one-cycle pulse; loads `init_counter` and begins keystream fetch.
- `init_counter`  in  32  block counter for the first block after `init`.
- `ks_start`  out  1  one-cycle request pulse to the generator.
- `ks_counter`  out  32  block counter for the requested block; stable from `ks_start` until `ks_done`.
- `ks_block`  in  512  keystream block; word i = `ks_block[i*32 +: 32]`.
- `ks_done`  in  1  one-cycle pulse; `ks_block` valid in the same cycle.
- `in_valid`, `in_ready`  in/out  1  input word handshake.
- `in_data`  in  32  plaintext or ciphertext word.
- `out_valid`, `out_ready`  out/in  1  output word handshake.
- `out_data`  out  32  `in_data` XOR keystream word.
- `busy`  out  1  high in any state other than IDLE.
- `ctr_exhausted`  out  1  sticky; set when the block with counter 0xFFFFFFFF is fully consumed.

## Operation
- FSM states: IDLE, REQ, WAIT, STREAM, HALT.
- IDLE: `in_ready`=0. On `init`, latch `init_counter` into the counter register and go to REQ.
- REQ: assert `ks_start` for exactly one cycle, then go to WAIT.
- WAIT: on `ks_done`, capture `ks_block` into the active buffer, reset the word index to 0, and go to STREAM.
- STREAM: `in_ready` = !`out_valid` || `out_ready`.
  - On an input handshake: `out_data` <= `in_data` ^ word[index], `out_valid` <= 1, and index increments.
  - When the word at index 15 is accepted and the counter is below 0xFFFFFFFF: the counter increments and the FSM goes to REQ.
  - When the word at index 15 is accepted and the counter is 0xFFFFFFFF: `ctr_exhausted` is set and the FSM goes to HALT. The counter never wraps.
- HALT: `in_ready`=0. The pending output still drains. Only `init` leaves HALT (to REQ); `init` also clears `ctr_exhausted`.
- `init` in STREAM: the current block and index are discarded. The pending output word still drains. Go to REQ with the new counter.
- `init` in REQ or WAIT is ignored, so no orphaned `ks_done` can occur.
- `ks_done` outside WAIT is ignored.
- The output register holds its data while `out_valid` && !`out_ready`.

## Timing
- Reset values:
  - `ks_start`, `out_valid`, `in_ready`, `busy`, `ctr_exhausted` = 0.
  - `ks_counter`, `out_data` = 0.
  - State = IDLE.
- Reset mid-operation drops the buffered block and the pending output immediately. No further `ks_start` is issued until `init`.
- `init` at cycle t gives `ks_start` at t+1.
- `ks_done` at cycle t gives `in_ready` at t+1.
- Data latency is 1 cycle: input accepted at t gives `out_valid`/`out_data` at t+1.
- Throughput is 1 word/cycle within a block when `out_ready` is held high.
- Without prefetch: after the last word of a block, the input stalls for 2 cycles plus the generator latency.

## Configuration
- `CHACHA_PREFETCH_EN` defined:
  - Adds a second 512-bit shadow buffer.
  - After a block is captured into the active buffer, counter+1 is requested immediately into the shadow buffer, unless the counter is 0xFFFFFFFF.
  - On acceptance of word 15 with the shadow buffer valid, the shadow is promoted to active in the same cycle, giving zero-bubble streaming across blocks.
  - If the shadow is not yet valid, the FSM waits in WAIT.
  - `init` during an outstanding prefetch is deferred until the prefetch's `ks_done`; that block is then discarded.
- `CHACHA_PREFETCH_EN` undefined: single buffer, behaviour exactly as in Operation.

## Test plan
- Reset then `init` with `init_counter`=1 → one `ks_start` pulse with `ks_counter`=1. Generator returns block B. Stream 16 words of 0x00000000 → `out_data` equals B words 0..15 in order, each 1 cycle after acceptance.
- Stream 17 words with `out_ready`=1 → after word 16, `ks_start` with `ks_counter`=2. Word 17 = `in_data` ^ word 0 of the new block. No prefetch: `in_ready`=0 during the refetch gap. Prefetch: no gap.
- `out_ready` held low for 5 cycles mid-block → `out_data` stable, `in_ready`=0, no words lost or duplicated.
- `init_counter`=0xFFFFFFFF, stream 16 words → `ctr_exhausted`=1, FSM in HALT, `in_ready`=0, no further `ks_start`. `init` with 5 → flag clears, `ks_counter`=5.
- Assert `reset` while in WAIT, then pulse `ks_done` → ignored. All outputs at reset values. Idle until `init`.
- `init` in STREAM at word 7 with `init_counter`=9 → next `ks_start` carries 9. The next accepted word uses word 0 of the new block.
